// File: rtl/dualport_ram_clr.sv
// ---------------------------------------------------------------------------
// dualport_ram_clr
//
// Simple dual-port RAM with one write port and one read port on a single
// clock. Read data is registered and qualified by a one-cycle valid strobe.
// A built-in clear sequencer sweeps every word to CLR_VAL after reset and
// whenever a clear is requested. User accesses are ignored while it runs.
//
// Parameters:
//   DATA_W  - data width in bits
//   ADDR_W  - address width in bits
//   DEPTH   - number of words (may be smaller than 2**ADDR_W)
//   RD_MODE - read/write collision behaviour: 0 = old data, 1 = new data
//   CLR_VAL - value the clear sweep writes into every word
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   we     - write enable
//   wa     - write address
//   Din    - write data
//   re     - read enable
//   ra     - read address
//   Dout   - registered read data
//   dvalid - one-cycle strobe marking new data on Dout
//   clr    - clear request, sampled on the rising edge
//   busy   - clear sweep in progress, user accesses are dropped
// ---------------------------------------------------------------------------
module dualport_ram_clr #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 4,
    parameter int                DEPTH   = (1 << ADDR_W),
    parameter int                RD_MODE = 0,
    parameter logic [DATA_W-1:0] CLR_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] Din,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] Dout,
    output logic              dvalid,
    input  logic              clr,
    output logic              busy
);

    typedef enum logic {
        CLEAR,
        IDLE
    } stateT;

    // One extra bit so that DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    stateT             state;
    stateT             nextState;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] nextPtr;

    logic              wrInRange;
    logic              rdInRange;
    logic              wrAccept;
    logic              rdAccept;

    logic              memWe;
    logic [ADDR_W-1:0] memWa;
    logic [DATA_W-1:0] memWd;

    logic [DATA_W-1:0] mem [DEPTH];

    // Addresses are judged against DEPTH, not the full address space, so a
    // non-power-of-two RAM silently drops out-of-range writes.
    assign wrInRange = ({1'b0, wa} < DEPTH_EXT);
    assign rdInRange = ({1'b0, ra} < DEPTH_EXT);
    assign wrAccept  = !busy && we && wrInRange;
    assign rdAccept  = !busy && re;

    // State register for the clear sequencer. Reset always lands in CLEAR
    // with the pointer at zero, so any interrupted sweep starts over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= nextState;
            ptr   <= nextPtr;
        end
    end

    // Next-state logic. In CLEAR the pointer walks up to the last word and
    // then hands over to IDLE; a clear request restarts the walk. In IDLE a
    // clear request re-enters CLEAR, while the current edge still services
    // the user access because busy is only raised from the next cycle.
    always_comb begin
        nextState = state;
        nextPtr   = ptr;
        busy      = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clr) begin
                    nextPtr = '0;
                end else if (ptr == LAST_ADDR) begin
                    nextState = IDLE;
                    nextPtr   = '0;
                end else begin
                    nextPtr = ptr + 1'b1;
                end
            end
            IDLE: begin
                if (clr) begin
                    nextState = CLEAR;
                    nextPtr   = '0;
                end
            end
            default: begin
                nextState = CLEAR;
                nextPtr   = '0;
            end
        endcase
    end

    // The array has a single write port shared between the sweep and the
    // user. During a sweep the sequencer owns it outright.
    always_comb begin
        memWe = wrAccept;
        memWa = wa;
        memWd = Din;
        if (busy) begin
            memWe = 1'b1;
            memWa = ptr;
            memWd = CLR_VAL;
        end
    end

    // Storage itself carries no reset; the sweep gives it a known state.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memWa] <= memWd;
        end
    end

    // Registered read port. The array update is non-blocking, so reading
    // mem[ra] on a colliding edge naturally returns the old word; the
    // write-first mode forwards Din instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Dout   <= '0;
            dvalid <= 1'b0;
        end else begin
            dvalid <= rdAccept;
            if (rdAccept) begin
                if (!rdInRange) begin
                    Dout <= '0;
                end else if ((RD_MODE == 1) && wrAccept && (wa == ra)) begin
                    Dout <= Din;
                end else begin
                    Dout <= mem[ra];
                end
            end
        end
    end

endmodule
